// File: rtl/aibcr3_dcc_dly_ctrl_if.sv
// Port bundle between the DCC detector/firmware side and the delay-line controller.
// pd_up/pd_dn are level inputs the controller samples only in its SAMPLE cycle; nothing here is a valid/ready pair.
interface aibcr3_dcc_dly_ctrl_if #(
    parameter int NCELL = 16,
    parameter int CW    = 5
);
    logic             en;
    logic             pd_up;
    logic             pd_dn;
    logic             ovr_en;
    logic [CW-1:0]    ovr_code;
    logic [NCELL-1:0] bk;
    logic [CW-1:0]    code;
    logic             lock;
    logic             busy;
    logic             at_min;
    logic             at_max;
    logic [1:0]       state_dbg;

    modport master (
        output en, pd_up, pd_dn, ovr_en, ovr_code,
        input  bk, code, lock, busy, at_min, at_max, state_dbg
    );

    modport slave (
        input  en, pd_up, pd_dn, ovr_en, ovr_code,
        output bk, code, lock, busy, at_min, at_max, state_dbg
    );
endinterface

// File: rtl/aibcr3_dcc_dly_ctrl.sv
// Closed-loop DCC delay-line controller: steps a saturating thermometer code from detector
// up/down decisions with a settle wait per step, and flags lock once the loop dithers.
module aibcr3_dcc_dly_ctrl #(
    parameter int NCELL      = 16,
    parameter int CW         = 5,
    parameter int INIT_CODE  = 8,
    parameter int SETTLE_CYC = 8,
    parameter int LOCK_REV   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    aibcr3_dcc_dly_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } dir_t;

    localparam logic [CW-1:0] MAX_CODE    = CW'(NCELL);
    localparam logic [CW-1:0] RESET_CODE  = CW'(INIT_CODE);
    localparam logic [7:0]    SETTLE_LOAD = 8'(SETTLE_CYC - 1);
    localparam logic [3:0]    LOCK_THRESH = 4'(LOCK_REV);

    state_t        state_q, state_d;
    logic [CW-1:0] code_q, code_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [3:0]    rev_q, rev_d;
    dir_t          last_q, last_d;
    logic          lock_q, lock_d;
    logic          busy_q, busy_d;

    dir_t          req_dir;
    logic          railed;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        rev_d   = rev_q;
        last_d  = last_q;
        lock_d  = lock_q;
        railed  = 1'b0;

        req_dir = DIR_NONE;
        if (bus.pd_up && !bus.pd_dn) begin
            req_dir = DIR_UP;
        end else if (bus.pd_dn && !bus.pd_up) begin
            req_dir = DIR_DN;
        end

        if (bus.ovr_en) begin
            code_d  = (bus.ovr_code > MAX_CODE) ? MAX_CODE : bus.ovr_code;
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
            rev_d   = 4'd0;
            last_d  = DIR_NONE;
            lock_d  = 1'b0;
        end else if (!bus.en) begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
            rev_d   = 4'd0;
            last_d  = DIR_NONE;
            lock_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end
                ST_SETTLE: begin
                    if (cnt_q == 8'd0) begin
                        state_d = ST_SAMPLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                ST_SAMPLE: begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                    if (req_dir != DIR_NONE) begin
                        // A blocked step at a rail breaks the dither exactly like a repeat.
                        railed = ((req_dir == DIR_UP) && (code_q == MAX_CODE)) ||
                                 ((req_dir == DIR_DN) && (code_q == '0));
                        if (!railed) begin
                            code_d = (req_dir == DIR_UP) ? (code_q + CW'(1)) : (code_q - CW'(1));
                        end
                        if (railed || (req_dir == last_q)) begin
                            rev_d  = 4'd0;
                            lock_d = 1'b0;
                        end else if (last_q != DIR_NONE) begin
                            rev_d = (rev_q == 4'd15) ? 4'd15 : (rev_q + 4'd1);
                            if (rev_d >= LOCK_THRESH) begin
                                lock_d = 1'b1;
                            end
                        end
                        last_d = req_dir;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            code_q  <= RESET_CODE;
            cnt_q   <= 8'd0;
            rev_q   <= 4'd0;
            last_q  <= DIR_NONE;
            lock_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            rev_q   <= rev_d;
            last_q  <= last_d;
            lock_q  <= lock_d;
            busy_q  <= busy_d;
        end
    end

    // Thermometer decode straight off the code register so bk tracks code with no added latency.
    always_comb begin
        bus.bk = '0;
        for (int i = 0; i < NCELL; i++) begin
            bus.bk[i] = (code_q > CW'(i));
        end
    end

    assign bus.code      = code_q;
    assign bus.lock      = lock_q;
    assign bus.busy      = busy_q;
    assign bus.at_min    = (code_q == '0);
    assign bus.at_max    = (code_q == MAX_CODE);
    assign bus.state_dbg = state_q;

endmodule
